// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the gshare/bimodal branch predictor.
// Holds the controller state encoding and the counter reset value.
package branch_pred_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    PRED,
    WAIT_FALL,
    TRAIN
  } state_t;

  // Weakly-not-taken is the largest value whose MSB is still 0.
  function automatic int unsigned weak_nt(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_pred_pht.sv
// Pattern history table: a flop array of saturating counters with a
// combinational read and a single-index saturating update.
module branch_pred_pht
  import branch_pred_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic             wr_taken
);

  localparam int             DEPTH   = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] ctr_q [DEPTH];

  assign rd_ctr = ctr_q[idx];

  // NOTE: this table is flops, not SRAM, so every entry can and must be reset;
  // a RAM macro would need an explicit init sequence instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
    end else if (wr_en) begin
      if (wr_taken && (ctr_q[idx] != CTR_MAX))
        ctr_q[idx] <= ctr_q[idx] + CTR_W'(1);
      else if (!wr_taken && (ctr_q[idx] != '0))
        ctr_q[idx] <= ctr_q[idx] - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_pred_gshare.sv
// Gshare/bimodal branch predictor controller: request edge detect, FSM,
// global history register, mispredict counter; PHT lives in a sub-module.
module branch_pred_gshare
  import branch_pred_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int CTR_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_data_avail,
  input  logic [7:0]       inst_addr,
  input  logic             direction_ground_truth,
  input  logic             mode_gshare,
  output logic             new_data_avail_posedge,
  output logic             pred_ready,
  output logic             prediction,
  output logic             training_done,
  output logic [CNT_W-1:0] mispred_count
);

  state_t            state_q, state_d;
  logic              nda_q;
  logic              rise;
  logic [HIST_W-1:0] ghr_q;
  logic [IDX_W-1:0]  index_q;
  logic              truth_q;
  logic [CTR_W-1:0]  rd_ctr;
  logic              unused_bits;

  assign rise        = new_data_avail & ~nda_q;
  assign unused_bits = ^{inst_addr[7:IDX_W], rd_ctr[CTR_W-2:0]};

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d                = state_q;
    new_data_avail_posedge = 1'b0;
    pred_ready             = 1'b0;
    training_done          = 1'b0;
    unique case (state_q)
      IDLE:      if (rise) state_d = READ;
      READ:      begin
                   new_data_avail_posedge = 1'b1;
                   state_d                = PRED;
                 end
      PRED:      begin
                   pred_ready = 1'b1;
                   state_d    = WAIT_FALL;
                 end
      WAIT_FALL: if (!new_data_avail) state_d = TRAIN;
      TRAIN:     begin
                   training_done = 1'b1;
                   state_d       = IDLE;
                 end
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      nda_q         <= 1'b0;
      ghr_q         <= '0;
      index_q       <= '0;
      truth_q       <= 1'b0;
      prediction    <= 1'b0;
      mispred_count <= '0;
    end else begin
      nda_q   <= new_data_avail;
      state_q <= state_d;
      if (state_q == IDLE && rise)
        index_q <= mode_gshare ? (inst_addr[IDX_W-1:0] ^ IDX_W'(ghr_q))
                               : inst_addr[IDX_W-1:0];
      // Loaded on the READ->PRED edge so it is already valid while pred_ready is high.
      if (state_q == READ)
        prediction <= rd_ctr[CTR_W-1];
      if (state_q == WAIT_FALL && !new_data_avail)
        truth_q <= direction_ground_truth;
      if (state_q == TRAIN) begin
        ghr_q <= (ghr_q << 1) | HIST_W'(truth_q);
        if ((prediction != truth_q) && (mispred_count != '1))
          mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

  branch_pred_pht #(
    .IDX_W(IDX_W),
    .CTR_W(CTR_W)
  ) u_pht (
    .clk     (clk),
    .rst     (rst),
    .idx     (index_q),
    .rd_ctr  (rd_ctr),
    .wr_en   (state_q == TRAIN),
    .wr_taken(truth_q)
  );

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Directed bench for branch_pred_gshare: a table of full transactions with
// hand-computed results, plus reset-abort and short-pulse/re-rise sequences.
module tb_branch_pred_gshare;

  localparam int IDX_W  = 6;
  localparam int HIST_W = 6;
  localparam int CTR_W  = 2;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             new_data_avail;
  logic [7:0]       inst_addr;
  logic             direction_ground_truth;
  logic             mode_gshare;
  logic             new_data_avail_posedge;
  logic             pred_ready;
  logic             prediction;
  logic             training_done;
  logic [CNT_W-1:0] mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_pred_gshare #(
    .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .new_data_avail        (new_data_avail),
    .inst_addr             (inst_addr),
    .direction_ground_truth(direction_ground_truth),
    .mode_gshare           (mode_gshare),
    .new_data_avail_posedge(new_data_avail_posedge),
    .pred_ready            (pred_ready),
    .prediction            (prediction),
    .training_done         (training_done),
    .mispred_count         (mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         do_rst;
    logic [7:0] addr;
    logic       mode;
    logic       truth;
    int         hold;
    logic [5:0] exp_idx;
    logic       exp_pred;
    logic [15:0] exp_mis;
    logic [5:0] exp_ghr;
    logic [1:0] exp_ctr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_pht_final(input int i);
    if (i == 'h00 || i == 'h01 || i == 'h06 || i == 'h1A) return 2'd2;
    if (i == 'h05 || i == 'h35) return 2'd0;
    return 2'd1;
  endfunction

  task automatic check_pht_reset(input string tag);
    for (int i = 0; i < 2 ** IDX_W; i++)
      check($sformatf("%s pht[%0d]", tag, i), 32'(dut.u_pht.ctr_q[i]), 32'd1);
  endtask

  task automatic do_reset();
    new_data_avail = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic txn(input vec_t v, input int k);
    @(posedge clk);
    #1;
    inst_addr              = v.addr;
    mode_gshare            = v.mode;
    direction_ground_truth = ~v.truth;
    new_data_avail         = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d posedge early", k), 32'(new_data_avail_posedge), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d posedge pulse", k), 32'(new_data_avail_posedge), 32'd1);
    check($sformatf("v%0d pred_ready early", k), 32'(pred_ready), 32'd0);
    check($sformatf("v%0d index", k), 32'(dut.index_q), 32'(v.exp_idx));
    @(negedge clk);
    check($sformatf("v%0d pred_ready", k), 32'(pred_ready), 32'd1);
    check($sformatf("v%0d prediction", k), 32'(prediction), 32'(v.exp_pred));
    if (v.hold > 0) begin
      repeat (v.hold) @(negedge clk);
      check($sformatf("v%0d held idle outputs", k),
            32'({pred_ready, training_done, new_data_avail_posedge}), 32'd0);
    end
    new_data_avail         = 1'b0;
    direction_ground_truth = v.truth;
    if (v.hold == 0) begin
      @(negedge clk);
      check($sformatf("v%0d training_done early", k), 32'(training_done), 32'd0);
    end
    @(negedge clk);
    check($sformatf("v%0d training_done", k), 32'(training_done), 32'd1);
    direction_ground_truth = ~v.truth;
    @(negedge clk);
    check($sformatf("v%0d training_done pulse", k), 32'(training_done), 32'd0);
    check($sformatf("v%0d mispred_count", k), 32'(mispred_count), 32'(v.exp_mis));
    check($sformatf("v%0d ghr", k), 32'(dut.ghr_q), 32'(v.exp_ghr));
    check($sformatf("v%0d counter", k), 32'(dut.u_pht.ctr_q[v.exp_idx]), 32'(v.exp_ctr));
    check($sformatf("v%0d prediction held", k), 32'(prediction), 32'(v.exp_pred));
  endtask

  initial begin
    //           rst  addr   mode  truth hold idx    pred  mis     ghr    ctr
    vecs[0]  = '{1'b1, 8'h05, 1'b0, 1'b1, 0, 6'h05, 1'b0, 16'd1, 6'h01, 2'd2};
    vecs[1]  = '{1'b0, 8'h05, 1'b0, 1'b1, 1, 6'h05, 1'b1, 16'd1, 6'h03, 2'd3};
    vecs[2]  = '{1'b0, 8'h05, 1'b0, 1'b1, 0, 6'h05, 1'b1, 16'd1, 6'h07, 2'd3};
    vecs[3]  = '{1'b1, 8'h05, 1'b0, 1'b0, 0, 6'h05, 1'b0, 16'd0, 6'h00, 2'd0};
    vecs[4]  = '{1'b0, 8'h05, 1'b0, 1'b0, 2, 6'h05, 1'b0, 16'd0, 6'h00, 2'd0};
    vecs[5]  = '{1'b0, 8'h05, 1'b0, 1'b0, 0, 6'h05, 1'b0, 16'd0, 6'h00, 2'd0};
    vecs[6]  = '{1'b0, 8'h05, 1'b0, 1'b0, 1, 6'h05, 1'b0, 16'd0, 6'h00, 2'd0};
    vecs[7]  = '{1'b0, 8'h05, 1'b0, 1'b0, 0, 6'h05, 1'b0, 16'd0, 6'h00, 2'd0};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 0, 6'h00, 1'b0, 16'd1, 6'h01, 2'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 6'h01, 1'b0, 16'd2, 6'h03, 2'd2};
    vecs[10] = '{1'b0, 8'h05, 1'b1, 1'b1, 0, 6'h06, 1'b0, 16'd3, 6'h07, 2'd2};
    vecs[11] = '{1'b0, 8'h05, 1'b0, 1'b0, 1, 6'h05, 1'b0, 16'd3, 6'h0E, 2'd0};
    vecs[12] = '{1'b0, 8'h3B, 1'b1, 1'b0, 0, 6'h35, 1'b0, 16'd3, 6'h1C, 2'd0};
    vecs[13] = '{1'b0, 8'hC6, 1'b1, 1'b1, 0, 6'h1A, 1'b0, 16'd4, 6'h39, 2'd2};

    rst                    = 1'b1;
    new_data_avail         = 1'b0;
    inst_addr              = 8'h00;
    direction_ground_truth = 1'b0;
    mode_gshare            = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs",
          32'({new_data_avail_posedge, pred_ready, prediction, training_done}), 32'd0);
    check("reset mispred_count", 32'(mispred_count), 32'd0);
    check("reset ghr", 32'(dut.ghr_q), 32'd0);
    check("reset index", 32'(dut.index_q), 32'd0);
    check_pht_reset("reset");

    for (int k = 0; k < 14; k++) begin
      if (vecs[k].do_rst) do_reset();
      txn(vecs[k], k);
    end
    for (int i = 0; i < 2 ** IDX_W; i++)
      check($sformatf("table pht[%0d]", i), 32'(dut.u_pht.ctr_q[i]), 32'(exp_pht_final(i)));

    // Reset while waiting for the falling edge aborts the transaction.
    @(posedge clk);
    #1;
    inst_addr      = 8'h23;
    mode_gshare    = 1'b1;
    new_data_avail = 1'b1;
    repeat (3) @(negedge clk);
    check("abort pred_ready", 32'(pred_ready), 32'd1);
    check("abort prediction", 32'(prediction), 32'd1);
    @(negedge clk);
    check("abort waiting", 32'(training_done), 32'd0);
    #2;
    rst                    = 1'b1;
    direction_ground_truth = 1'b1;
    #1;
    check("abort async outputs",
          32'({new_data_avail_posedge, pred_ready, prediction, training_done}), 32'd0);
    check("abort async mispred_count", 32'(mispred_count), 32'd0);
    check("abort async ghr", 32'(dut.ghr_q), 32'd0);
    new_data_avail = 1'b0;
    repeat (2) @(negedge clk);
    check("abort no training in reset", 32'(training_done), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort quiet c%0d", c), 32'({training_done, pred_ready}), 32'd0);
    end
    check("abort ghr after", 32'(dut.ghr_q), 32'd0);
    check_pht_reset("abort");

    // One-cycle request pulse, then a re-rise during TRAIN that must be ignored.
    @(posedge clk);
    #1;
    inst_addr              = 8'h0A;
    mode_gshare            = 1'b0;
    direction_ground_truth = 1'b0;
    new_data_avail         = 1'b1;
    @(posedge clk);
    #1;
    new_data_avail = 1'b0;
    @(negedge clk);
    check("short posedge pulse", 32'(new_data_avail_posedge), 32'd1);
    @(negedge clk);
    check("short pred_ready", 32'(pred_ready), 32'd1);
    check("short prediction", 32'(prediction), 32'd0);
    @(negedge clk);
    check("short wait_fall", 32'(training_done), 32'd0);
    @(negedge clk);
    check("short training_done", 32'(training_done), 32'd1);
    new_data_avail = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("re-rise ignored c%0d", c),
            32'({new_data_avail_posedge, pred_ready, training_done}), 32'd0);
    end
    new_data_avail = 1'b0;
    check("short counter", 32'(dut.u_pht.ctr_q[6'h0A]), 32'd0);
    check("short mispred_count", 32'(mispred_count), 32'd0);
    check("short ghr", 32'(dut.ghr_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
